// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V style control unit: sequences fetch/decode/execute/memory/writeback
// states and drives the datapath enables and mux selects for each state.
module multicycle_control_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OP_CODE,
  input  logic [2:0] Func3,
  input  logic       ZF,
  input  logic       SF,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUop,
  output logic [1:0] IMMSrc,
  output logic       Illegal,
  output logic       InstrDone,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state_reg;
  state_t state_next;

  logic pc_write_next;
  logic ir_write_next;
  logic reg_write_next;
  logic mem_write_next;
  logic illegal_next;
  logic instr_done_next;
  logic branch_taken;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Immediate format depends only on the opcode, independent of state.
  always_comb begin
    IMMSrc = 2'b00;
    case (OP_CODE)
      OP_STORE:  IMMSrc = 2'b01;
      OP_BRANCH: IMMSrc = 2'b10;
      OP_JAL:    IMMSrc = 2'b11;
      default:   IMMSrc = 2'b00;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (Func3)
      3'b000:  branch_taken = ZF;
      3'b001:  branch_taken = ~ZF;
      3'b100:  branch_taken = SF;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next      = S_FETCH;
    pc_write_next   = 1'b0;
    ir_write_next   = 1'b0;
    reg_write_next  = 1'b0;
    mem_write_next  = 1'b0;
    illegal_next    = 1'b0;
    instr_done_next = 1'b0;
    AdrSrc          = 1'b0;
    ALUSrcA         = 2'b00;
    ALUSrcB         = 2'b00;
    ResultSrc       = 2'b00;
    ALUop           = 2'b00;

    case (state_reg)
      S_FETCH: begin
        ALUSrcB       = 2'b10;
        ResultSrc     = 2'b10;
        ir_write_next = MemReady;
        pc_write_next = MemReady;
        state_next    = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU precomputes PC + imm so a branch target is ready in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (OP_CODE)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_JAL:            state_next = S_JAL;
          OP_BRANCH:         state_next = S_BRANCH;
          default: begin
            illegal_next = 1'b1;
            state_next   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        case (OP_CODE)
          OP_LOAD:  state_next = S_MEMREAD;
          OP_STORE: state_next = S_MEMWRITE;
          default:  state_next = S_FETCH;
        endcase
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc       = 2'b01;
        reg_write_next  = 1'b1;
        instr_done_next = 1'b1;
        state_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc          = 1'b1;
        mem_write_next  = 1'b1;
        instr_done_next = MemReady;
        state_next      = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUop      = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUop      = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_next  = 1'b1;
        instr_done_next = 1'b1;
        state_next      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the jump target while ALU forms PC+4 for the link register.
        ALUSrcA       = 2'b01;
        ALUSrcB       = 2'b10;
        pc_write_next = 1'b1;
        state_next    = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA         = 2'b10;
        ALUop           = 2'b01;
        pc_write_next   = branch_taken;
        instr_done_next = 1'b1;
        state_next      = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Write enables are masked by reset so nothing commits while it is held.
  assign PCWrite   = pc_write_next & RST;
  assign IRWrite   = ir_write_next & RST;
  assign RegWrite  = reg_write_next & RST;
  assign MemWrite  = mem_write_next & RST;
  assign Illegal   = illegal_next & RST;
  assign InstrDone = instr_done_next & RST;
  assign State     = state_reg;

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below (clock and reset first).
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST  input  1  asynchronous reset, active-low.
REQ-004 OP_CODE  input  7  opcode field of the instruction register.
REQ-005 Func3  input  3  funct3 field of the instruction register.
REQ-006 ZF / SF  input  1 each  ALU zero and sign flags, valid in the BRANCH state.
REQ-007 MemReady  input  1  memory completes the current access this cycle.
REQ-008 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  datapath enables/selects.
REQ-009 ALUSrcA, ALUSrcB, ResultSrc, ALUop, IMMSrc  output  2 each  datapath mux selects and ALU class.
REQ-010 Illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-011 InstrDone  output  1  one-cycle pulse in the final state of each instruction.
REQ-012 State  output  4  current state encoding, for debug.

Function
REQ-013 State encoding SHALL be as follows: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BRANCH=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-014 Every output not listed for a state SHALL be 0 in that state.
REQ-015 IMMSrc SHALL be combinational from OP_CODE in all states: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, others -> 00.
REQ-016 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUop=00, ResultSrc=10, IRWrite=PCWrite=MemReady; hold while MemReady=0; go to DECODE when MemReady=1.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUop=00 (branch target into ALUOut).
REQ-018 DECODE next state: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1101111 -> JAL, 1100011 -> BRANCH.
REQ-019 DECODE with any other opcode SHALL assert Illegal and go to FETCH.
REQ-020 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUop=00; next state MEMREAD for 0000011, MEMWRITE for 0100011.
REQ-021 MEMREAD: AdrSrc=1, ResultSrc=00; hold until MemReady=1, then go to MEMWB.
REQ-022 MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1; next state FETCH.
REQ-023 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until MemReady=1; InstrDone=MemReady; then go to FETCH.
REQ-024 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUop=10. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUop=10. Both go to ALUWB.
REQ-025 ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1; next state FETCH.
REQ-026 JAL: ALUSrcA=01, ALUSrcB=10, ALUop=00, ResultSrc=00, PCWrite=1; next state ALUWB (rd <- PC+4).
REQ-027 BRANCH outputs: ALUSrcA=10, ALUSrcB=00, ALUop=01, ResultSrc=00, InstrDone=1; next state FETCH.
REQ-028 BRANCH PCWrite SHALL be (Mealy): Func3 000 -> ZF, 001 -> ~ZF, 100 -> SF, any other value -> 0.
REQ-029 Latencies with MemReady held 1 SHALL be: lw 5 cycles; sw 4; R-type/I-type 4; jal 4; branch 3.
REQ-030 Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle of latency.
REQ-031 OP_CODE and Func3 changes outside DECODE/MEMADR/BRANCH SHALL NOT affect the state sequence.

Reset
REQ-032 While RST=0: State=FETCH, and PCWrite, IRWrite, RegWrite, MemWrite, Illegal and InstrDone forced to 0 regardless of MemReady.
REQ-033 RST asserted mid-instruction SHALL abort it immediately, with no further write enable asserted.
REQ-034 After RST deasserts, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-035 The bench SHALL cover these scenarios:
- lw (0000011), MemReady=1 -> States 0,1,2,3,4; RegWrite=1 only in state 4; InstrDone once.
- sw (0100011), MemReady=0 for 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles, then FETCH; RegWrite never 1.
- beq (1100011, Func3=000): ZF=1 -> PCWrite=1 in BRANCH; ZF=0 -> 0. bne (001) with ZF=0 -> 1. blt (100) with SF=1 -> 1. Func3=010 -> 0.
- OP_CODE=1111111 -> Illegal=1 in DECODE for exactly 1 cycle, next State=0, no write enables.
- jal (1101111) -> States 0,1,9,7; PCWrite in 9; RegWrite in 7; IMMSrc=11 throughout.
- RST pulled low in MEMWRITE with MemReady=0 -> MemWrite=0 immediately, State=0; after release, fetch resumes.
